// File: rtl/conv_stream_p.sv
// 3x3 streaming convolution over LANES+2 row bands, two-stage AXI-Stream output.
// Define CONV_STREAM_RELU_EN for unsigned ReLU clamp; default is signed byte clamp.
module conv_stream_p #(
  parameter int IMG_W    = 48,
  parameter int LANES    = 3,
  parameter int OUT_ROWS = 48,
  parameter int SHIFT    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [71:0]              wdata,
  input  logic                     wdata_valid,
  input  logic [(LANES+2)*8-1:0]   s_pix_tdata,
  input  logic                     s_pix_tvalid,
  output logic                     s_pix_tready,
  output logic [LANES*8-1:0]       m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int BANDS = OUT_ROWS / LANES;
  localparam int ROWS  = LANES + 2;
  localparam int CW    = $clog2(IMG_W);
  localparam int BW    = (BANDS > 1) ? $clog2(BANDS) : 1;

  logic [71:0]                wt_q, wt_d;
  logic [2:0][ROWS*8-1:0]     win_q, win_d;
  logic [CW-1:0]              col_q, col_d;
  logic [BW-1:0]              band_q, band_d;
  logic                       w_vld_q, w_vld_d;
  logic                       w_last_q, w_last_d;
  logic                       s1_vld_q, s1_vld_d;
  logic                       s1_last_q, s1_last_d;
  logic [LANES-1:0][20:0]     s1_acc_q, s1_acc_d;
  logic                       m_vld_q, m_vld_d;
  logic                       m_last_q, m_last_d;
  logic [LANES*8-1:0]         m_data_q, m_data_d;
  logic [LANES-1:0][20:0]     acc_c;
  logic                       en;
  logic                       accept;

  assign en            = !m_vld_q || m_axis_tready;
  assign accept        = s_pix_tvalid && en;
  assign s_pix_tready  = en;
  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign frame_done    = m_vld_q && m_axis_tready && m_last_q;
  assign busy          = (|col_q) || (|band_q) || w_vld_q
                       || s1_vld_q || m_vld_q;

  function automatic logic [7:0] sat(input logic [20:0] a);
    logic signed [20:0] s;
    s = $signed(a) >>> SHIFT;
`ifdef CONV_STREAM_RELU_EN
    if (s < 21'sd0)        sat = 8'h00;
    else if (s > 21'sd255) sat = 8'hFF;
    else                   sat = s[7:0];
`else
    if (s < -21'sd128)     sat = 8'h80;
    else if (s > 21'sd127) sat = 8'h7F;
    else                   sat = s[7:0];
`endif
  endfunction

  // Per-lane 3x3 multiply-accumulate over the current window.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      acc_c[k] = '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          acc_c[k] = acc_c[k] + 21'(
            $signed(wt_q[8*(8-3*i-j) +: 8]) *
            $signed({1'b0, win_q[j][8*(k+i) +: 8]}));
        end
      end
    end
  end

  // Next-state: weight load, window shift, counters, pipeline.
  always_comb begin
    wt_d      = wt_q;
    win_d     = win_q;
    col_d     = col_q;
    band_d    = band_q;
    w_vld_d   = w_vld_q;
    w_last_d  = w_last_q;
    s1_vld_d  = s1_vld_q;
    s1_last_d = s1_last_q;
    s1_acc_d  = s1_acc_q;
    m_vld_d   = m_vld_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    if (wdata_valid && !busy) wt_d = wdata;
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = s_pix_tdata;
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        if (band_q == BW'(BANDS - 1)) band_d = '0;
        else                          band_d = band_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (en) begin
      w_vld_d   = accept && (col_q >= CW'(2));
      w_last_d  = accept && (col_q == CW'(IMG_W - 1))
                && (band_q == BW'(BANDS - 1));
      s1_vld_d  = w_vld_q;
      s1_last_d = w_last_q;
      s1_acc_d  = acc_c;
      m_vld_d   = s1_vld_q;
      m_last_d  = s1_vld_q && s1_last_q;
      for (int k = 0; k < LANES; k++) begin
        m_data_d[8*k +: 8] = sat(s1_acc_q[k]);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wt_q      <= '0;
      win_q     <= '0;
      col_q     <= '0;
      band_q    <= '0;
      w_vld_q   <= 1'b0;
      w_last_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_acc_q  <= '0;
      m_vld_q   <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wt_q      <= wt_d;
      win_q     <= win_d;
      col_q     <= col_d;
      band_q    <= band_d;
      w_vld_q   <= w_vld_d;
      w_last_q  <= w_last_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s1_acc_q  <= s1_acc_d;
      m_vld_q   <= m_vld_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

endmodule

// File: tb/tb_conv_stream_p.sv
// Self-checking bench for conv_stream_p with a frame-level reference model.
// Honours CONV_STREAM_RELU_EN the same way as the design.
module tb_conv_stream_p;

  localparam int IW = 8;
  localparam int LN = 3;
  localparam int OR = 6;
  localparam int SH = 0;
  localparam int NB = OR / LN;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] wdata;
  logic        wdata_valid;
  logic [39:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        busy;
  logic        frame_done;

  conv_stream_p #(
    .IMG_W(IW), .LANES(LN), .OUT_ROWS(OR), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst),
    .wdata(wdata), .wdata_valid(wdata_valid),
    .s_pix_tdata(s_tdata), .s_pix_tvalid(s_tvalid),
    .s_pix_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic bp_low  = 1'b0;
  logic bp_rand = 1'b0;
  logic [25:0] obs_q[$];
  logic [24:0] exp_q[$];
  int rd_idx = 0;
  int w_m[3][3];
  int pix[NB][IW][LN+2];

  // Sink: drive tready on the falling edge, log handshakes before the rise.
  always @(negedge clk) begin
    m_tready = bp_low ? 1'b0 :
               bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    #2;
    if (m_tvalid && m_tready)
      obs_q.push_back({m_tdata, m_tlast, frame_done});
  end

  task automatic chk(input string tag,
                     input logic [63:0] o, input logic [63:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [7:0] sat(input int a);
    int s;
    s = a >>> SH;
`ifdef CONV_STREAM_RELU_EN
    if (s < 0) s = 0;
    if (s > 255) s = 255;
`else
    if (s < -128) s = -128;
    if (s > 127) s = 127;
`endif
    return 8'(s);
  endfunction

  function automatic logic [23:0] model(input int b, input int c);
    logic [23:0] r;
    int acc;
    r = '0;
    for (int k = 0; k < LN; k++) begin
      acc = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          acc += w_m[i][j] * pix[b][c-2+j][k+i];
      r[8*k +: 8] = sat(acc);
    end
    return r;
  endfunction

  function automatic logic [71:0] pack_w();
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[8*(8-3*i-j) +: 8] = 8'(w_m[i][j]);
    return v;
  endfunction

  function automatic logic [39:0] pack_col(input int b, input int c);
    logic [39:0] v;
    for (int r = 0; r < LN + 2; r++) v[8*r +: 8] = 8'(pix[b][c][r]);
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic send_col(input logic [39:0] d);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    while (!s_tready && n < 200) begin
      step();
      n++;
    end
    chk("send_timeout", 64'(n < 200), 64'(1));
    step();
  endtask

  task automatic do_stall(input bit junk);
    int n;
    logic [23:0] d0;
    logic l0;
    s_tvalid = 1'b0;
    bp_low = 1'b1;
    step();
    n = 0;
    while (!m_tvalid && n < 50) begin
      step();
      n++;
    end
    chk("stall_vld", 64'(m_tvalid), 64'(1));
    d0 = m_tdata;
    l0 = m_tlast;
    if (junk) begin
      wdata = ~pack_w();
      wdata_valid = 1'b1;
    end
    for (int t = 0; t < 5; t++) begin
      step();
      wdata_valid = 1'b0;
      chk("stall_data", 64'(m_tdata), 64'(d0));
      chk("stall_last", 64'(m_tlast), 64'(l0));
      chk("stall_tvalid", 64'(m_tvalid), 64'(1));
      chk("stall_sready", 64'(s_tready), 64'(0));
    end
    bp_low = 1'b0;
  endtask

  task automatic send_frame(input int ncols, input int stall_at,
                            input bit load_w, input bit junk,
                            input bit lat);
    int idx;
    idx = 0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < IW; c++) begin
        if (idx < ncols) begin
          if (load_w && idx == 0) begin
            wdata = pack_w();
            wdata_valid = 1'b1;
          end
          if (idx == stall_at) do_stall(junk);
          send_col(pack_col(b, c));
          wdata_valid = 1'b0;
          if (c >= 2)
            exp_q.push_back({model(b, c), 1'(b == NB-1 && c == IW-1)});
          if (lat && idx == 2) begin
            s_tvalid = 1'b0;
            step();
            chk("latency_1", 64'(m_tvalid), 64'(0));
            step();
            chk("latency_2", 64'(m_tvalid), 64'(1));
          end
          idx++;
        end
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    logic [25:0] o;
    n = 0;
    while (obs_q.size() - rd_idx < exp_q.size() && n < 500) begin
      step();
      n++;
    end
    for (int t = 0; t < 6; t++) step();
    chk({tag, "_count"}, 64'(obs_q.size() - rd_idx), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd_idx + i < obs_q.size()) begin
        o = obs_q[rd_idx + i];
        chk({tag, "_data"}, 64'(o[25:2]), 64'(exp_q[i][24:1]));
        chk({tag, "_last"}, 64'(o[1]), 64'(exp_q[i][0]));
        chk({tag, "_fdone"}, 64'(o[0]), 64'(exp_q[i][0]));
      end
    end
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_sready"}, 64'(s_tready), 64'(1));
    rd_idx = obs_q.size();
    exp_q.delete();
  endtask

  task automatic set_w(input int v);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) w_m[i][j] = v;
  endtask

  task automatic set_pix(input int v);
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < IW; c++)
        for (int r = 0; r < LN + 2; r++) pix[b][c][r] = v;
  endtask

  task automatic rand_all();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w_m[i][j] = int'($urandom_range(0, 255)) - 128;
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < IW; c++)
        for (int r = 0; r < LN + 2; r++)
          pix[b][c][r] = int'($urandom_range(0, 255));
  endtask

  initial begin
    rst = 1'b1;
    wdata = '0;
    wdata_valid = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    step();
    step();
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tdata", 64'(m_tdata), 64'(0));
    chk("rst_tlast", 64'(m_tlast), 64'(0));
    chk("rst_fdone", 64'(frame_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    step();
    chk("rst_sready", 64'(s_tready), 64'(1));

    set_w(1);
    set_pix(10);
    send_frame(NB*IW, -1, 1'b1, 1'b0, 1'b1);
    drain("ones");

    set_w(0);
    w_m[1][1] = 1;
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < IW; c++)
        for (int r = 0; r < LN + 2; r++) pix[b][c][r] = c + r;
    send_frame(NB*IW, -1, 1'b1, 1'b0, 1'b0);
    drain("center");

    set_w(127);
    set_pix(255);
    send_frame(NB*IW, -1, 1'b1, 1'b0, 1'b0);
    drain("satpos");

    set_w(-1);
    set_pix(10);
    send_frame(NB*IW, -1, 1'b1, 1'b0, 1'b0);
    drain("satneg");

    rand_all();
    bp_rand = 1'b1;
    send_frame(NB*IW, 13, 1'b1, 1'b1, 1'b0);
    drain("rand_bp");
    bp_rand = 1'b0;

    rand_all();
    send_frame(IW + 5, -1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'(0));
    rd_idx = obs_q.size();
    exp_q.delete();
    rand_all();
    send_frame(NB*IW, -1, 1'b1, 1'b0, 1'b0);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
